imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Responder end of the instruction-fetch interface driven by the program-counter register.
//  Accepts word-fetch requests (address plus valid/ready).
//  Reads a word-addressed instruction RAM and returns the instruction in request order.
//  Returns data through an output valid/ready port that holds up to 2 responses.
//  Flags misaligned and out-of-range fetches.
//  A separate program port loads the RAM from the bench or the boot loader.
// PARAMETERS
//  DEPTH_WORDS  256            number of 32-bit words in the RAM; power of 2, >= 4
//  NOP_INSTR    32'h00000013   instruction returned on an error response (addi x0,x0,0)
// PORTS
//  clk        in   1   clock; all state updates on its rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   fetch request present
//  req_addr   in   32  byte address of the fetch (PC value)
//  req_ready  out  1   responder can accept a request this cycle
//  rsp_valid  out  1   response at head of output buffer
//  rsp_ready  in   1   consumer takes response this cycle
//  rsp_instr  out  32  fetched instruction, or NOP_INSTR on error
//  rsp_addr   out  32  byte address echoed from the request
//  rsp_err    out  1   1 = misaligned or out-of-range fetch
//  prog_we    in   1   write enable for the program port
//  prog_addr  in   32  byte address for the program write; bits [1:0] ignored
//  prog_data  in   32  word to write
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - Output buffer and in-flight stage emptied.
//   - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
//   - RAM contents are not cleared.
//  Reset mid-operation:
//   - All accepted but undelivered requests are silently dropped.
//   - The first request after reset release is treated as fresh.
//  Occupancy:
//   - occ = in-flight (0/1) + buffered (0..2).
//   - req_ready = (occ < 2) OR (occ == 2 AND rsp_valid AND rsp_ready).
//   - req_ready is combinational from state and rsp_ready; it never depends on req_valid.
//   - Immediately after reset, req_ready = 1.
//  Accept: a request is accepted when req_valid AND req_ready at a rising edge.
//   - The RAM is read on that edge into a 1-stage in-flight register.
//   - On the next edge the result moves into the 2-entry output FIFO.
//   - Latency: rsp_valid rises one cycle after acceptance when the FIFO was empty.
//     Example: accept at edge N -> rsp_valid=1 after edge N+1.
//  Throughput: 1 response/cycle when rsp_ready is held at 1.
//  Ordering: responses are delivered strictly in acceptance order.
//  Output FIFO:
//   - Head entry drives rsp_instr/rsp_addr/rsp_err.
//   - Head is popped when rsp_valid AND rsp_ready at an edge.
//   - Outputs stay stable while rsp_valid=1 AND rsp_ready=0.
//   - Simultaneous push and pop in one cycle is legal; count is unchanged.
//  Error rules, evaluated at acceptance:
//   - req_addr[1:0] != 0 -> rsp_err=1.
//   - req_addr[31:2] >= DEPTH_WORDS -> rsp_err=1.
//   - On error: rsp_instr = NOP_INSTR, no RAM read, rsp_addr = req_addr unchanged.
//  RAM index: req_addr[$clog2(DEPTH_WORDS)+1:2].
//  Program port:
//   - prog_we writes prog_data to word prog_addr[31:2] on the edge.
//   - Out-of-range program writes are ignored.
//   - Program writes are independent of the fetch handshake.
//   - Same-edge write and fetch of the same word: the fetch returns the OLD word
//     (read-before-write).
//   - A write at edge N is visible to fetches accepted at edge N+1 or later.
//  rsp_* values while rsp_valid=0 are don't-care, but never X after reset.
// TESTING
//  T1 reset/latency:
//   - Stimulus: prog word 0 = 32'h00500093; release reset; request addr 0 with rsp_ready=1.
//   - Required: rsp_valid one cycle after accept; instr=00500093, err=0, addr=0.
//  T2 stream:
//   - Stimulus: requests to 0,4,8,...,28 back-to-back, rsp_ready=1.
//   - Required: 8 in-order responses on consecutive cycles; req_ready stays 1.
//  T3 backpressure:
//   - Stimulus: rsp_ready=0, req_valid=1 to addrs 0,4,8,...
//   - Required: exactly 2 accepted; req_ready=0; outputs stable.
//   - Then set rsp_ready=1: resumes with no loss or duplication.
//  T4 errors:
//   - Stimulus: request addr 2, then addr 4*DEPTH_WORDS.
//   - Required: both give err=1, instr=00000013, echoed addrs 2 and 1024 (default depth).
//  T5 write/read collision:
//   - Stimulus: word 3 = A; same edge write B to addr 12 and accept fetch of 12.
//   - Required: response A; the next fetch of 12 returns B.
//  T6 reset mid-operation:
//   - Stimulus: 2 responses buffered, pulse reset low asynchronously.
//   - Required: rsp_valid=0 immediately; no stale response after release; RAM still holds its data.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
//
// Responder side of the instruction-fetch interface. Fetch requests are
// accepted with a valid/ready handshake, the word-addressed instruction RAM is
// read into a single in-flight register, and the result moves on the next
// edge into a 2-entry output FIFO that feeds the response valid/ready port.
// Misaligned or out-of-range fetches produce an error response carrying
// NOP_INSTR. A separate program port writes the RAM at any time.
//
// Ports:
//   clk        clock, rising-edge
//   reset      asynchronous active-low reset (RAM contents are kept)
//   req_valid  fetch request present
//   req_addr   byte address of the fetch
//   req_ready  responder can accept a request this cycle
//   rsp_valid  response available at FIFO head
//   rsp_ready  consumer takes the head response this cycle
//   rsp_instr  fetched instruction, or NOP_INSTR on error
//   rsp_addr   byte address echoed from the request
//   rsp_err    misaligned or out-of-range fetch
//   prog_we    program-port write enable
//   prog_addr  program-port byte address (bits [1:0] ignored)
//   prog_data  program-port write data
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_instr,
   output logic [31:0] rsp_addr,
   output logic        rsp_err,
   input  logic        prog_we,
   input  logic [31:0] prog_addr,
   input  logic [31:0] prog_data
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   logic        ifValid_q;
   logic [31:0] ifInstr_q;
   logic [31:0] ifAddr_q;
   logic        ifErr_q;

   logic [31:0] fifoInstr_q [2];
   logic [31:0] fifoAddr_q  [2];
   logic [1:0]  fifoErr_q;
   logic        wrPtr_q;
   logic        rdPtr_q;
   logic [1:0]  count_q;
   logic [1:0]  count_d;

   logic [1:0]  occ;
   logic        push;
   logic        pop;
   logic        accept;
   logic        reqErr;
   logic        progInRange;
   logic        unusedProgBits;

   // An address is out of range exactly when any bit above the word index is
   // set, which avoids a wide magnitude compare.
   assign reqErr      = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
   assign progInRange = ~|prog_addr[31:AW+2];

   assign unusedProgBits = &{1'b0, prog_addr[1:0]};

   assign push      = ifValid_q;
   assign rsp_valid = (count_q != 2'd0);
   assign pop       = rsp_valid && rsp_ready;
   assign occ       = {1'b0, ifValid_q} + count_q;

   // A full pipe can still take a request when the head leaves this cycle:
   // the in-flight entry (if any) then fits in the slot freed by the pop.
   assign req_ready = (occ < 2'd2) || ((occ == 2'd2) && pop);
   assign accept    = req_valid && req_ready;

   assign rsp_instr = fifoInstr_q[rdPtr_q];
   assign rsp_addr  = fifoAddr_q[rdPtr_q];
   assign rsp_err   = fifoErr_q[rdPtr_q];

   // Program port. The RAM has no reset so its contents survive a reset
   // pulse; out-of-range writes are dropped rather than aliased.
   always_ff @(posedge clk) begin
      if (prog_we && progInRange) begin
         mem[prog_addr[AW+1:2]] <= prog_data;
      end
   end

   // In-flight stage. Reading the RAM with a non-blocking read on the same
   // edge as a program write gives read-before-write behaviour.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifValid_q <= 1'b0;
         ifInstr_q <= 32'h0;
         ifAddr_q  <= 32'h0;
         ifErr_q   <= 1'b0;
      end else begin
         ifValid_q <= accept;
         if (accept) begin
            ifAddr_q  <= req_addr;
            ifErr_q   <= reqErr;
            ifInstr_q <= reqErr ? NOP_INSTR : mem[req_addr[AW+1:2]];
         end
      end
   end

   // Next FIFO count; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Output FIFO. Entries are cleared on reset so the response outputs read
   // as zero rather than stale or unknown values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifoInstr_q[0] <= 32'h0;
         fifoInstr_q[1] <= 32'h0;
         fifoAddr_q[0]  <= 32'h0;
         fifoAddr_q[1]  <= 32'h0;
         fifoErr_q      <= 2'b00;
         wrPtr_q        <= 1'b0;
         rdPtr_q        <= 1'b0;
         count_q        <= 2'd0;
      end else begin
         if (push) begin
            fifoInstr_q[wrPtr_q] <= ifInstr_q;
            fifoAddr_q[wrPtr_q]  <= ifAddr_q;
            fifoErr_q[wrPtr_q]   <= ifErr_q;
            wrPtr_q              <= ~wrPtr_q;
         end
         if (pop) begin
            rdPtr_q <= ~rdPtr_q;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_responder
//
// Directed bench for imem_fetch_responder. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge, so a request driven at
// falling edge n is accepted at the next rising edge and its response is
// visible at falling edge n+2 when the FIFO was empty.
// ---------------------------------------------------------------------------
module tb_imem_fetch_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_data;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] memModel [256];

   imem_fetch_responder dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Program-port write; the model only records in-range words.
   task automatic applyStimulus(input logic [31:0] byteAddr, input logic [31:0] data);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = byteAddr;
      prog_data = data;
      if (byteAddr[31:10] == 22'd0) memModel[byteAddr[9:2]] = data;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Reset values, readiness right after reset, and RAM preload.
   task automatic test_reset;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      rsp_ready = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 32'h0;
      prog_data = 32'h0;
      #2 reset = 1'b0;
      #1;
      compared++;
      if ({rsp_valid, rsp_err, rsp_addr, rsp_instr} !== 66'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got v=%b e=%b a=%h i=%h, expected all zero",
                  rsp_valid, rsp_err, rsp_addr, rsp_instr);
      end
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      applyStimulus(32'h0, 32'h00500093);
      for (int i = 1; i < 8; i++) applyStimulus(32'(4 * i), 32'h00110000 + 32'(i * 'h101));
      applyStimulus(32'd1020, 32'hDEADBEEF);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Single fetch of word 0: response one cycle after acceptance.
   task automatic test_latency;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      compared++;
      if (rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL latency_early: rsp_valid got %b expected 0", rsp_valid);
      end
      @(negedge clk);
      compared++;
      if ({rsp_valid, rsp_err, rsp_addr, rsp_instr} !== {1'b1, 1'b0, 32'h0, 32'h00500093}) begin
         mismatched++;
         $display("[TB] FAIL latency_rsp: got v=%b e=%b a=%h i=%h, expected v=1 e=0 a=0 i=00500093",
                  rsp_valid, rsp_err, rsp_addr, rsp_instr);
      end
      @(negedge clk);
      compared++;
      if (rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL latency_drain: rsp_valid got %b expected 0", rsp_valid);
      end
   endtask

   // Eight back-to-back fetches with the consumer always ready.
   task automatic test_stream;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            compared++;
            if ({rsp_valid, rsp_err, rsp_addr, rsp_instr} !==
                {1'b1, 1'b0, 32'(4 * (k - 2)), memModel[k - 2]}) begin
               mismatched++;
               $display("[TB] FAIL stream_rsp%0d: got v=%b e=%b a=%h i=%h, expected v=1 e=0 a=%h i=%h",
                        k - 2, rsp_valid, rsp_err, rsp_addr, rsp_instr, 32'(4 * (k - 2)), memModel[k - 2]);
            end
         end
         if (k < 8) begin
            compared++;
            if (req_ready !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL stream_ready%0d: got %b expected 1", k, req_ready);
            end
            req_valid = 1'b1;
            req_addr  = 32'(4 * k);
         end else begin
            req_valid = 1'b0;
         end
      end
      @(negedge clk);
      compared++;
      if (rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL stream_drain: rsp_valid got %b expected 0", rsp_valid);
      end
   endtask

   // Consumer stalled: only two requests fit, head stays stable, then drains.
   task automatic test_back_to_back_backpressure;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      @(negedge clk);
      req_addr = 32'h4;
      @(negedge clk);
      req_addr = 32'h8;
      compared++;
      if (req_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_ready_low: got %b expected 0", req_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         compared++;
         if ({req_ready, rsp_valid, rsp_err, rsp_addr, rsp_instr} !==
             {1'b0, 1'b1, 1'b0, 32'h0, 32'h00500093}) begin
            mismatched++;
            $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b e=%b a=%h i=%h, expected rdy=0 v=1 e=0 a=0 i=00500093",
                     k, req_ready, rsp_valid, rsp_err, rsp_addr, rsp_instr);
         end
      end
      rsp_ready = 1'b1;
      #1;
      compared++;
      if (req_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL bp_ready_on_pop: got %b expected 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      compared++;
      if ({rsp_valid, rsp_addr, rsp_instr} !== {1'b1, 32'h4, memModel[1]}) begin
         mismatched++;
         $display("[TB] FAIL bp_resume1: got v=%b a=%h i=%h, expected v=1 a=4 i=%h",
                  rsp_valid, rsp_addr, rsp_instr, memModel[1]);
      end
      @(negedge clk);
      compared++;
      if ({rsp_valid, rsp_addr, rsp_instr} !== {1'b1, 32'h8, memModel[2]}) begin
         mismatched++;
         $display("[TB] FAIL bp_resume2: got v=%b a=%h i=%h, expected v=1 a=8 i=%h",
                  rsp_valid, rsp_addr, rsp_instr, memModel[2]);
      end
      @(negedge clk);
      compared++;
      if (rsp_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_no_dup: rsp_valid got %b expected 0", rsp_valid);
      end
   endtask

   // Misaligned, just out of range, last valid word, and an ignored
   // out-of-range program write that must not alias onto word 0.
   task automatic test_errors;
      logic [31:0] addrs [4];
      logic [65:0] expect_rsp [4];
      applyStimulus(32'd1024, 32'hBADBAD00);
      addrs[0] = 32'd2;
      addrs[1] = 32'd1024;
      addrs[2] = 32'd1020;
      addrs[3] = 32'd0;
      expect_rsp[0] = {1'b1, 1'b1, 32'd2,    32'h00000013};
      expect_rsp[1] = {1'b1, 1'b1, 32'd1024, 32'h00000013};
      expect_rsp[2] = {1'b1, 1'b0, 32'd1020, 32'hDEADBEEF};
      expect_rsp[3] = {1'b1, 1'b0, 32'd0,    32'h00500093};
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            compared++;
            if ({rsp_valid, rsp_err, rsp_addr, rsp_instr} !== expect_rsp[k - 2]) begin
               mismatched++;
               $display("[TB] FAIL err_rsp%0d: got v=%b e=%b a=%h i=%h, expected %h",
                        k - 2, rsp_valid, rsp_err, rsp_addr, rsp_instr, expect_rsp[k - 2]);
            end
         end
         req_valid = (k < 4);
         if (k < 4) req_addr = addrs[k];
      end
   endtask

   // Same-edge write and fetch of word 3 returns the old word.
   task automatic test_collision;
      applyStimulus(32'd12, 32'hAAAA0001);
      @(negedge clk);
      rsp_ready = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 32'd12;
      prog_data = 32'hBBBB0002;
      req_valid = 1'b1;
      req_addr  = 32'd12;
      @(negedge clk);
      prog_we = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      compared++;
      if ({rsp_valid, rsp_err, rsp_instr} !== {1'b1, 1'b0, 32'hAAAA0001}) begin
         mismatched++;
         $display("[TB] FAIL collision_old: got v=%b e=%b i=%h, expected v=1 e=0 i=aaaa0001",
                  rsp_valid, rsp_err, rsp_instr);
      end
      @(negedge clk);
      compared++;
      if ({rsp_valid, rsp_err, rsp_instr} !== {1'b1, 1'b0, 32'hBBBB0002}) begin
         mismatched++;
         $display("[TB] FAIL collision_new: got v=%b e=%b i=%h, expected v=1 e=0 i=bbbb0002",
                  rsp_valid, rsp_err, rsp_instr);
      end
      memModel[3] = 32'hBBBB0002;
      @(negedge clk);
   endtask

   // Asynchronous reset with two buffered responses drops them; RAM survives.
   task automatic test_reset_mid;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'd4;
      @(negedge clk);
      req_addr = 32'd8;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      compared++;
      if (rsp_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rstmid_filled: rsp_valid got %b expected 1", rsp_valid);
      end
      #2 reset = 1'b0;
      #1;
      compared++;
      if ({rsp_valid, req_ready, rsp_err, rsp_addr, rsp_instr} !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
         mismatched++;
         $display("[TB] FAIL rstmid_async: got v=%b rdy=%b e=%b a=%h i=%h, expected v=0 rdy=1 rest zero",
                  rsp_valid, req_ready, rsp_err, rsp_addr, rsp_instr);
      end
      @(negedge clk);
      reset     = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         compared++;
         if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_stale%0d: rsp_valid got %b expected 0", k, rsp_valid);
         end
      end
      req_valid = 1'b1;
      req_addr  = 32'd12;
      @(negedge clk);
      req_addr = 32'd4;
      @(negedge clk);
      req_valid = 1'b0;
      compared++;
      if ({rsp_valid, rsp_addr, rsp_instr} !== {1'b1, 32'd12, 32'hBBBB0002}) begin
         mismatched++;
         $display("[TB] FAIL rstmid_ram3: got v=%b a=%h i=%h, expected v=1 a=c i=bbbb0002",
                  rsp_valid, rsp_addr, rsp_instr);
      end
      @(negedge clk);
      compared++;
      if ({rsp_valid, rsp_addr, rsp_instr} !== {1'b1, 32'd4, 32'h00110101}) begin
         mismatched++;
         $display("[TB] FAIL rstmid_ram1: got v=%b a=%h i=%h, expected v=1 a=4 i=00110101",
                  rsp_valid, rsp_addr, rsp_instr);
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_latency();
      test_stream();
      test_back_to_back_backpressure();
      test_errors();
      test_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
